memctrl_rep: RTL and testbench

Parametrised successor of the SRAM-style memory controller: same CSB/CE/WEB/OEB/ADDR/IDATA/ODATA host protocol, generalised in address/data width and depth, plus a register-based spare-word repair table (BISR remap) and busy/error status. Sits between the chip-level pad interface and the on-chip word array. The array is inferred internally; repair entries come from the BIST/BISR engine via REP_LOAD.

---
 rtl/memctrl_pkg.sv | 20 ++
 rtl/memctrl_spare_tab.sv | 80 ++++++++
 rtl/memctrl_rep.sv | 123 ++++++++++++
 tb/tb_memctrl_rep.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/memctrl_pkg.sv
// memctrl_rep shared types and defaults.
// FSM state encoding and spare-entry layout.
package memctrl_pkg;
  localparam int AW_DEF     = 16;
  localparam int DW_DEF     = 8;
  localparam int DEPTH_DEF  = 4096;
  localparam int NSPARE_DEF = 4;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    HOLD
  } state_e;

  typedef struct packed {
    logic              valid;
    logic [AW_DEF-1:0] tag;
    logic [DW_DEF-1:0] data;
  } spare_ent_t;
endpackage

// File: rtl/memctrl_spare_tab.sv
// Spare-word repair CAM: load port, lookup,
// spare data read/write and full flag.
module memctrl_spare_tab
  import memctrl_pkg::*;
#(
  parameter int AW     = AW_DEF,
  parameter int DW     = DW_DEF,
  parameter int NSPARE = NSPARE_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_i,
  input  logic [AW-1:0] load_addr_i,
  input  logic [AW-1:0] addr_i,
  input  logic          we_i,
  input  logic [DW-1:0] wdata_i,
  output logic          hit_o,
  output logic [DW-1:0] rdata_o,
  output logic          full_o
);
  localparam int IXW = (NSPARE > 1) ? $clog2(NSPARE) : 1;

  typedef struct packed {
    logic          valid;
    logic [AW-1:0] tag;
    logic [DW-1:0] data;
  } ent_t;

  ent_t           ent_q [NSPARE];
  ent_t           ent_d [NSPARE];
  logic [IXW-1:0] hit_idx;
  logic [IXW-1:0] free_idx;
  logic           free_ok;
  logic           dup;
  logic [NSPARE-1:0] vld;

  // Lookup, duplicate check, free slot and next table
  always_comb begin
    ent_d    = ent_q;
    hit_o    = 1'b0;
    hit_idx  = '0;
    dup      = 1'b0;
    free_ok  = 1'b0;
    free_idx = '0;
    for (int i = 0; i < NSPARE; i++) begin
      vld[i] = ent_q[i].valid;
      if (ent_q[i].valid && ent_q[i].tag == addr_i
          && !hit_o) begin
        hit_o   = 1'b1;
        hit_idx = IXW'(i);
      end
      if (ent_q[i].valid && ent_q[i].tag == load_addr_i)
        dup = 1'b1;
      if (!ent_q[i].valid && !free_ok) begin
        free_ok  = 1'b1;
        free_idx = IXW'(i);
      end
    end
    if (load_i && !dup && free_ok) begin
      ent_d[free_idx].valid = 1'b1;
      ent_d[free_idx].tag   = load_addr_i;
      ent_d[free_idx].data  = '0;
    end
    if (we_i && hit_o)
      ent_d[hit_idx].data = wdata_i;
  end

  assign rdata_o = ent_q[hit_idx].data;
  assign full_o  = &vld;

  // Table registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NSPARE; i++)
        ent_q[i] <= '0;
    end else begin
      ent_q <= ent_d;
    end
  end
endmodule

// File: rtl/memctrl_rep.sv
// SRAM-style memory controller with spare-word
// repair, busy and sticky out-of-range status.
module memctrl_rep
  import memctrl_pkg::*;
#(
  parameter int AW     = AW_DEF,
  parameter int DW     = DW_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int NSPARE = NSPARE_DEF
) (
  input  logic          CLK,
  input  logic          RSTN,
  input  logic          CSB,
  input  logic          CE,
  input  logic          WEB,
  input  logic          OEB,
  input  logic [AW-1:0] ADDR,
  input  logic [DW-1:0] IDATA,
  output logic [DW-1:0] ODATA,
  input  logic          REP_LOAD,
  input  logic [AW-1:0] REP_ADDR,
  output logic          REP_FULL,
  output logic          BUSY,
  output logic          ERR
);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_e        state_q, state_d;
  logic [AW-1:0] a_addr_q;
  logic [DW-1:0] a_data_q;
  logic          a_web_q;
  logic [DW-1:0] rd_data_q;
  logic          rd_valid_q;
  logic [DW-1:0] odata_q;
  logic          err_q;
  logic [DW-1:0] mem [DEPTH];

  logic          start;
  logic          in_acc;
  logic          in_rng;
  logic [IW-1:0] a_idx;
  logic          sp_hit;
  logic [DW-1:0] sp_rdata;

  assign start  = CE && !CSB;
  assign in_acc = (state_q == ACCESS);
  assign in_rng = {1'b0, a_addr_q} < (AW+1)'(DEPTH);
  assign a_idx  = a_addr_q[IW-1:0];

  memctrl_spare_tab #(
    .AW     (AW),
    .DW     (DW),
    .NSPARE (NSPARE)
  ) u_spare (
    .clk         (CLK),
    .rst_n       (RSTN),
    .load_i      (REP_LOAD),
    .load_addr_i (REP_ADDR),
    .addr_i      (a_addr_q),
    .we_i        (in_acc && !a_web_q),
    .wdata_i     (a_data_q),
    .hit_o       (sp_hit),
    .rdata_o     (sp_rdata),
    .full_o      (REP_FULL)
  );

  // State register
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state: one ACCESS cycle, HOLD until CSB high
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = ACCESS;
      ACCESS:  state_d = HOLD;
      HOLD:    if (CSB) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Access latch, read capture, ODATA and ERR
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      a_addr_q   <= '0;
      a_data_q   <= '0;
      a_web_q    <= 1'b1;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      odata_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      odata_q <= (!OEB && rd_valid_q) ? rd_data_q : '0;
      if (state_q == IDLE && start) begin
        a_addr_q   <= ADDR;
        a_data_q   <= IDATA;
        a_web_q    <= WEB;
        rd_valid_q <= 1'b0;
      end
      if (in_acc) begin
        if (!sp_hit && !in_rng) err_q <= 1'b1;
        if (a_web_q) begin
          rd_valid_q <= 1'b1;
          if (sp_hit)      rd_data_q <= sp_rdata;
          else if (in_rng) rd_data_q <= mem[a_idx];
          else             rd_data_q <= '0;
        end
      end
    end
  end

  // Array write; contents are never reset
  always_ff @(posedge CLK) begin
    if (in_acc && !a_web_q && !sp_hit && in_rng)
      mem[a_idx] <= a_data_q;
  end

  assign ODATA = odata_q;
  assign BUSY  = (state_q != IDLE);
  assign ERR   = err_q;
endmodule

// File: tb/tb_memctrl_rep.sv
// Directed bench for memctrl_rep with a read
// scoreboard queue and backdoor array checks.
module tb_memctrl_rep;
  logic        CLK = 1'b0;
  logic        RSTN;
  logic        CSB, CE, WEB, OEB;
  logic [15:0] ADDR;
  logic [7:0]  IDATA;
  logic [7:0]  ODATA;
  logic        REP_LOAD;
  logic [15:0] REP_ADDR;
  logic        REP_FULL, BUSY, ERR;

  int ncmp = 0;
  int nerr = 0;
  logic [7:0] sb [$];
  logic [7:0] rnd [10];

  memctrl_rep dut (
    .CLK      (CLK),
    .RSTN     (RSTN),
    .CSB      (CSB),
    .CE       (CE),
    .WEB      (WEB),
    .OEB      (OEB),
    .ADDR     (ADDR),
    .IDATA    (IDATA),
    .ODATA    (ODATA),
    .REP_LOAD (REP_LOAD),
    .REP_ADDR (REP_ADDR),
    .REP_FULL (REP_FULL),
    .BUSY     (BUSY),
    .ERR      (ERR)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h",
             tag, obs, exp);
    end
  endtask

  // entry and exit at a negedge with the bus idle
  task automatic do_write(input logic [15:0] a,
                          input logic [7:0] d);
    CSB = 1'b0; CE = 1'b1; WEB = 1'b0;
    ADDR = a; IDATA = d;
    @(negedge CLK);
    check("wr_busy_hi", 32'(BUSY), 32'd1);
    CE = 1'b0; ADDR = 16'hFFFF; IDATA = 8'h00;
    @(negedge CLK);
    CSB = 1'b1; WEB = 1'b1;
    @(negedge CLK);
    check("wr_busy_lo", 32'(BUSY), 32'd0);
  endtask

  task automatic do_read(input logic [15:0] a,
                         input logic [7:0] e);
    logic [7:0] x;
    sb.push_back(e);
    CSB = 1'b0; CE = 1'b1; WEB = 1'b1; OEB = 1'b1;
    ADDR = a;
    @(negedge CLK);
    check("rd_busy_hi", 32'(BUSY), 32'd1);
    CE = 1'b0;
    @(negedge CLK);
    check("rd_oeb_hi_zero", 32'(ODATA), 32'd0);
    OEB = 1'b0;
    @(negedge CLK);
    x = sb.pop_front();
    check("rd_data", 32'(ODATA), 32'(x));
    @(negedge CLK);
    check("rd_data_hold", 32'(ODATA), 32'(x));
    OEB = 1'b1; CSB = 1'b1;
    @(negedge CLK);
    check("rd_oeb_rise_zero", 32'(ODATA), 32'd0);
    check("rd_busy_lo", 32'(BUSY), 32'd0);
  endtask

  task automatic rep_load(input logic [15:0] a);
    REP_LOAD = 1'b1; REP_ADDR = a;
    @(negedge CLK);
    REP_LOAD = 1'b0;
    @(negedge CLK);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit hit");
    $fatal(1, "timeout");
  end

  initial begin
    RSTN = 1'b0; CSB = 1'b1; CE = 1'b0;
    WEB = 1'b1; OEB = 1'b1;
    ADDR = '0; IDATA = '0;
    REP_LOAD = 1'b0; REP_ADDR = '0;
    repeat (2) @(negedge CLK);
    check("rst_odata", 32'(ODATA), 32'd0);
    check("rst_busy", 32'(BUSY), 32'd0);
    check("rst_err", 32'(ERR), 32'd0);
    check("rst_full", 32'(REP_FULL), 32'd0);
    RSTN = 1'b1;
    @(negedge CLK);

    do_write(16'h0003, 8'hA5);
    do_read(16'h0003, 8'hA5);

    CSB = 1'b0; CE = 1'b0; ADDR = 16'h0003;
    @(negedge CLK);
    check("ce0_no_access", 32'(BUSY), 32'd0);
    CSB = 1'b1;
    @(negedge CLK);

    for (int i = 0; i < 10; i++) begin
      rnd[i] = 8'($urandom);
      do_write(16'(i), rnd[i]);
      do_read(16'(i), rnd[i]);
    end
    check("rand_err", 32'(ERR), 32'd0);

    rep_load(16'h0005);
    do_write(16'h0005, 8'h3C);
    do_read(16'h0005, 8'h3C);
    check("spare_arr5", 32'(dut.mem[5]), 32'(rnd[5]));
    rep_load(16'h0005);

    do_write(16'h1000, 8'h77);
    check("oor_wr_err", 32'(ERR), 32'd1);
    do_read(16'h1000, 8'h00);
    check("oor_err_sticky", 32'(ERR), 32'd1);
    rep_load(16'h1000);
    do_write(16'h1000, 8'h77);
    do_read(16'h1000, 8'h77);

    rep_load(16'h0020);
    check("dup_not_loaded", 32'(REP_FULL), 32'd0);
    rep_load(16'h0021);
    check("full_set", 32'(REP_FULL), 32'd1);
    rep_load(16'h0023);
    do_write(16'h0023, 8'h5A);
    check("full_to_array", 32'(dut.mem[35]), 32'h5A);
    do_read(16'h0023, 8'h5A);

    do_write(16'h0002, 8'h11);
    CSB = 1'b0; CE = 1'b1; WEB = 1'b0;
    ADDR = 16'h0002; IDATA = 8'h99;
    @(negedge CLK);
    RSTN = 1'b0;
    #1;
    check("mrst_busy", 32'(BUSY), 32'd0);
    check("mrst_odata", 32'(ODATA), 32'd0);
    check("mrst_err", 32'(ERR), 32'd0);
    check("mrst_full", 32'(REP_FULL), 32'd0);
    CSB = 1'b1; CE = 1'b0; WEB = 1'b1;
    @(negedge CLK);
    RSTN = 1'b1;
    @(negedge CLK);
    do_read(16'h0002, 8'h11);
    do_read(16'h0005, rnd[5]);
    check("mrst_err_after", 32'(ERR), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nerr);
    $finish;
  end
endmodule
